// File: rtl/regs_wb_arbiter_pkg.sv
// Shared core types for the integer register file write-back path.
// Holds register-file geometry, the write-request record and the grant-source encoding.
package pkg_rv_core;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int REG_NUM    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_EX     = 2'd1,
    GNT_FIFO   = 2'd2,
    GNT_STARVE = 2'd3
  } wb_gnt_e;

endpackage

// File: rtl/regs_wb_arbiter_if.sv
// Bus bundle between EX/LSU/ID, the write-back arbiter and the register file port.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface regs_wb_arbiter_if;
  import pkg_rv_core::*;

  logic                  ex_valid_i;
  logic [REG_ADDR_W-1:0] ex_rd_i;
  logic [XLEN-1:0]       ex_wdata_i;
  logic                  ex_stall_o;

  // LSU valid/ready: a result transfers on a cycle with lsu_valid_i & lsu_ready_o;
  // while valid is high and ready is low the producer holds rd/wdata unchanged.
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [REG_ADDR_W-1:0] lsu_rd_i;
  logic [XLEN-1:0]       lsu_wdata_i;

  logic                  issue_long_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic [REG_NUM-1:0]    busy_o;

  logic [REG_ADDR_W-1:0] rd_waddr_o;
  logic [XLEN-1:0]       rd_wdata_o;
  logic                  rd_wr_en_o;

  modport slave (
    input  ex_valid_i, ex_rd_i, ex_wdata_i,
    input  lsu_valid_i, lsu_rd_i, lsu_wdata_i,
    input  issue_long_i, issue_rd_i,
    output ex_stall_o, lsu_ready_o, busy_o,
    output rd_waddr_o, rd_wdata_o, rd_wr_en_o
  );

  modport master (
    output ex_valid_i, ex_rd_i, ex_wdata_i,
    output lsu_valid_i, lsu_rd_i, lsu_wdata_i,
    output issue_long_i, issue_rd_i,
    input  ex_stall_o, lsu_ready_o, busy_o,
    input  rd_waddr_o, rd_wdata_o, rd_wr_en_o
  );

endinterface

// File: rtl/regs_wb_arbiter_wb_fifo.sv
// Synchronous buffer for long-latency write-back results (load/divide).
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
  import pkg_rv_core::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  wb_req_t din_i,
  input  logic    pop_i,
  output wb_req_t dout_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter: merges EX results with buffered long-latency results onto the
// single register-file write port and tracks outstanding long-latency destinations.
module regs_wb_arbiter
  import pkg_rv_core::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              sys_clk_i,
  input logic              rst_i,
  regs_wb_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [REG_NUM-1:0] BIT0 = REG_NUM'(1);

  wb_gnt_e               gnt;
  wb_req_t               gnt_req, fifo_head, lsu_req;
  logic                  fifo_full, fifo_empty, fifo_pop, lsu_push;
  logic [SW-1:0]         starve_q, starve_d;
  logic [REG_NUM-1:0]    busy_q, busy_d, set_mask, clr_mask;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

  assign lsu_req  = {bus.lsu_rd_i, bus.lsu_wdata_i};
  assign lsu_push = bus.lsu_valid_i & ~fifo_full;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (sys_clk_i),
    .rst_i   (rst_i),
    .push_i  (lsu_push),
    .din_i   (lsu_req),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    gnt      = GNT_NONE;
    gnt_req  = '0;
    starve_d = '0;
    if (starve_q == STARVE_MAX && !fifo_empty) begin
      gnt     = GNT_STARVE;
      gnt_req = fifo_head;
    end else if (bus.ex_valid_i) begin
      gnt     = GNT_EX;
      gnt_req = {bus.ex_rd_i, bus.ex_wdata_i};
      // Count only cycles in which a buffered result was actually waiting.
      if (!fifo_empty)
        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_ONE;
    end else if (!fifo_empty) begin
      gnt     = GNT_FIFO;
      gnt_req = fifo_head;
    end
  end

  assign fifo_pop = (gnt == GNT_STARVE) || (gnt == GNT_FIFO);

  always_comb begin
    set_mask = bus.issue_long_i ? (BIT0 << bus.issue_rd_i) : '0;
    clr_mask = fifo_pop ? (BIT0 << fifo_head.rd) : '0;
    busy_d   = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    wr_en_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt != GNT_NONE && gnt_req.rd != '0) begin
      wr_en_d = 1'b1;
      waddr_d = gnt_req.rd;
      wdata_d = gnt_req.data;
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
      busy_q   <= '0;
      wr_en_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      wr_en_q  <= wr_en_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // The pop's clear is visible in the pop cycle itself; a same-cycle re-issue keeps the bit.
  assign bus.busy_o      = busy_q & ~(clr_mask & ~set_mask);
  assign bus.ex_stall_o  = (gnt == GNT_STARVE);
  assign bus.lsu_ready_o = ~fifo_full;
  assign bus.rd_wr_en_o  = wr_en_q;
  assign bus.rd_waddr_o  = waddr_q;
  assign bus.rd_wdata_o  = wdata_q;

  a_no_waw: assert property (@(posedge sys_clk_i) disable iff (rst_i)
    bus.ex_valid_i |-> !bus.busy_o[bus.ex_rd_i]);

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference of the arbitration rules.
module tb_regs_wb_arbiter;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regs_wb_arbiter_if bus ();

  regs_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .sys_clk_i (clk),
    .rst_i     (rst),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic [36:0] m_fifo[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_wr_en;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  // per-cycle observed / expected
  logic        obs_ready, obs_stall, obs_wr_en;
  logic [31:0] obs_busy, obs_wdata;
  logic [4:0]  obs_waddr;
  logic [71:0] obs_v, exp_v;
  logic        ex_taken, lsu_taken;

  task automatic clear_inputs();
    bus.ex_valid_i   = 1'b0;
    bus.ex_rd_i      = '0;
    bus.ex_wdata_i   = '0;
    bus.lsu_valid_i  = 1'b0;
    bus.lsu_rd_i     = '0;
    bus.lsu_wdata_i  = '0;
    bus.issue_long_i = 1'b0;
    bus.issue_rd_i   = '0;
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_starve = 0;
    m_busy   = '0;
    m_wr_en  = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    ex_taken  = 1'b1;
    lsu_taken = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Advance one clock: sample combinational outputs mid-cycle, registered ones after the edge.
  task automatic model_cycle();
    logic        ready, stall, pop, gnt;
    logic [4:0]  g_rd, h_rd;
    logic [31:0] g_data, busy_now;
    @(negedge clk);
    obs_ready = bus.lsu_ready_o;
    obs_stall = bus.ex_stall_o;
    obs_busy  = bus.busy_o;
    ready  = (m_fifo.size() < FIFO_DEPTH);
    pop    = 1'b0;
    stall  = 1'b0;
    gnt    = 1'b0;
    g_rd   = '0;
    g_data = '0;
    h_rd   = (m_fifo.size() > 0) ? m_fifo[0][36:32] : 5'd0;
    if (m_starve == STARVE_LIMIT && m_fifo.size() > 0) begin
      pop = 1'b1; stall = 1'b1;
    end else if (bus.ex_valid_i) begin
      gnt = 1'b1; g_rd = bus.ex_rd_i; g_data = bus.ex_wdata_i;
    end else if (m_fifo.size() > 0) begin
      pop = 1'b1;
    end
    busy_now = m_busy;
    if (pop && !(bus.issue_long_i && bus.issue_rd_i == h_rd)) busy_now[h_rd] = 1'b0;
    busy_now[0] = 1'b0;
    ex_taken  = bus.ex_valid_i && !stall;
    lsu_taken = bus.lsu_valid_i && ready;
    @(posedge clk);
    #1;
    if (pop) begin
      gnt = 1'b1; g_rd = m_fifo[0][36:32]; g_data = m_fifo[0][31:0];
      void'(m_fifo.pop_front());
      m_starve = 0;
    end else if (ex_taken) begin
      m_starve = (m_fifo.size() == 0) ? 0 :
                 ((m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1);
    end else begin
      m_starve = 0;
    end
    if (lsu_taken) m_fifo.push_back({bus.lsu_rd_i, bus.lsu_wdata_i});
    m_busy = busy_now;
    if (bus.issue_long_i && bus.issue_rd_i != 5'd0) m_busy[bus.issue_rd_i] = 1'b1;
    if (gnt && g_rd != 5'd0) begin
      m_wr_en = 1'b1; m_waddr = g_rd; m_wdata = g_data;
    end else begin
      m_wr_en = 1'b0;
    end
    obs_wr_en = bus.rd_wr_en_o;
    obs_waddr = bus.rd_waddr_o;
    obs_wdata = bus.rd_wdata_o;
    obs_v = {obs_ready, obs_stall, obs_busy, obs_wr_en, obs_waddr, obs_wdata};
    exp_v = {ready, stall, busy_now, m_wr_en, m_waddr, m_wdata};
  endtask

  task automatic test_reset();
    clear_inputs();
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.lsu_ready_o, bus.ex_stall_o, bus.busy_o, bus.rd_wr_en_o, bus.rd_waddr_o, bus.rd_wdata_o}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 5'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state: got ready=%b stall=%b busy=%h en=%b addr=%h data=%h, want 1 0 0 0 0 0",
               bus.lsu_ready_o, bus.ex_stall_o, bus.busy_o, bus.rd_wr_en_o, bus.rd_waddr_o, bus.rd_wdata_o);
    end
    do_reset();
  endtask

  task automatic test_ex_write();
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd5; bus.ex_wdata_i = 32'hDEADBEEF;
    model_cycle();
    bus.ex_valid_i = 1'b0;
    n_vec++;
    if ({obs_wr_en, obs_waddr, obs_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL ex_write: got en=%b addr=%0d data=%h, want 1 5 deadbeef", obs_wr_en, obs_waddr, obs_wdata);
    end
    model_cycle();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL ex_write_idle: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_long_latency();
    bus.issue_long_i = 1'b1; bus.issue_rd_i = 5'd7;
    model_cycle();
    bus.issue_long_i = 1'b0;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd7; bus.lsu_wdata_i = 32'h1234;
    model_cycle();
    n_vec++;
    if (obs_busy[7] !== 1'b1) begin n_err++; $display("FAIL busy7_set: got %b want 1", obs_busy[7]); end
    bus.lsu_valid_i = 1'b0;
    model_cycle();
    n_vec++;
    if ({obs_busy[7], obs_wr_en, obs_waddr, obs_wdata} !== {1'b0, 1'b1, 5'd7, 32'h1234}) begin
      n_err++;
      $display("FAIL long_pop: got busy7=%b en=%b addr=%0d data=%h, want 0 1 7 1234",
               obs_busy[7], obs_wr_en, obs_waddr, obs_wdata);
    end
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL long_model: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_starvation();
    int stall_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (ex_taken || !bus.ex_valid_i) begin
        bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd3; bus.ex_wdata_i = $urandom;
      end
      bus.lsu_valid_i = (i < 2);
      bus.lsu_rd_i    = 5'(20 + i);
      bus.lsu_wdata_i = 32'hA000_0000 + 32'(i);
      model_cycle();
      if (obs_stall === 1'b1 && stall_at < 0) stall_at = i;
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL starve_c%0d: got %h want %h", i, obs_v, exp_v); end
    end
    n_vec++;
    if (stall_at !== 5) begin n_err++; $display("FAIL starve_cycle: stall first at %0d want 5", stall_at); end
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      model_cycle();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL starve_drain%0d: got %h want %h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_x0();
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd0; bus.ex_wdata_i = 32'hFFFFFFFF;
    model_cycle();
    n_vec++;
    if (obs_wr_en !== 1'b0) begin n_err++; $display("FAIL x0_ex: got en=%b want 0", obs_wr_en); end
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL x0_ex_model: got %h want %h", obs_v, exp_v); end
    clear_inputs();
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd0; bus.lsu_wdata_i = 32'h5555AAAA;
    model_cycle();
    bus.lsu_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_cycle();
      n_vec++;
      if (obs_v !== exp_v || obs_wr_en !== 1'b0) begin
        n_err++; $display("FAIL x0_lsu%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_set_wins();
    bus.issue_long_i = 1'b1; bus.issue_rd_i = 5'd9;
    model_cycle();
    bus.issue_long_i = 1'b0;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd9; bus.lsu_wdata_i = 32'h99;
    model_cycle();
    bus.lsu_valid_i = 1'b0;
    bus.issue_long_i = 1'b1; bus.issue_rd_i = 5'd9;
    model_cycle();
    bus.issue_long_i = 1'b0;
    n_vec++;
    if ({obs_busy[9], obs_wr_en, obs_waddr} !== {1'b1, 1'b1, 5'd9}) begin
      n_err++; $display("FAIL set_wins_pop: got busy9=%b en=%b addr=%0d want 1 1 9", obs_busy[9], obs_wr_en, obs_waddr);
    end
    model_cycle();
    n_vec++;
    if (obs_busy[9] !== 1'b1 || obs_v !== exp_v) begin
      n_err++; $display("FAIL set_wins_after: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.issue_long_i = 1'b1; bus.issue_rd_i = 5'd7;
    model_cycle();
    bus.issue_rd_i = 5'd9;
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd3; bus.ex_wdata_i = 32'h3333;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd7; bus.lsu_wdata_i = 32'h7777;
    model_cycle();
    bus.issue_long_i = 1'b0;
    bus.lsu_rd_i = 5'd9; bus.lsu_wdata_i = 32'h9999;
    model_cycle();
    bus.lsu_valid_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.busy_o, bus.lsu_ready_o} !== {32'h0000_0280, 1'b0}) begin
      n_err++; $display("FAIL pre_reset: got busy=%h ready=%b want 00000280 0", bus.busy_o, bus.lsu_ready_o);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.lsu_ready_o, bus.ex_stall_o, bus.busy_o, bus.rd_wr_en_o, bus.rd_waddr_o, bus.rd_wdata_o}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 5'h0, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset: got ready=%b stall=%b busy=%h en=%b addr=%h data=%h, want 1 0 0 0 0 0",
               bus.lsu_ready_o, bus.ex_stall_o, bus.busy_o, bus.rd_wr_en_o, bus.rd_waddr_o, bus.rd_wdata_o);
    end
    do_reset();
    model_cycle();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL post_reset: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!(bus.ex_valid_i && !ex_taken)) begin
        bus.ex_valid_i = ($urandom_range(0, 3) != 0);
        bus.ex_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
        bus.ex_wdata_i = $urandom;
      end
      if (!(bus.lsu_valid_i && !lsu_taken)) begin
        bus.lsu_valid_i = ($urandom_range(0, 2) == 0);
        bus.lsu_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
        bus.lsu_wdata_i = $urandom;
      end
      bus.issue_long_i = ($urandom_range(0, 3) == 0);
      bus.issue_rd_i   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
      model_cycle();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL random_c%0d: got %h want %h", c, obs_v, exp_v); end
    end
    clear_inputs();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_ex_write();
    test_long_latency();
    test_starvation();
    test_x0();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
